// File: rtl/sum_operand_recover_seq.sv
// Sequential recovery of operand B = S - A from a WIDTH+1-bit sum and operand A,
// DIGIT bits per cycle, LSB first, with a registered borrow and a range flag.
module sum_operand_recover_seq #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   in_sum,
  input  logic [WIDTH-1:0] in_opa,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_opb,
  output logic             out_err
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned StepW = (N > 1) ? $clog2(N) : 1;
  localparam logic [StepW-1:0] LastStep = StepW'(N - 1);

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] sum_lo_q, sum_lo_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             sum_msb_q, sum_msb_d;
  logic             borrow_q, borrow_d;
  logic             err_q, err_d;
  logic [StepW-1:0] step_q, step_d;
  logic [DIGIT:0]   diff;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRun;
      StRun:   if (step_q == LastStep) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are pure register decodes; no input-to-output path
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    out_opb   = opb_q;
    out_err   = err_q;
  end

  // Operands shift right each step so the active digit is always at bit 0;
  // result digits enter at the top of work_q and reach their place after N steps.
  always_comb begin
    diff      = {1'b0, sum_lo_q[DIGIT-1:0]} - {1'b0, opa_q[DIGIT-1:0]}
                - (DIGIT+1)'(borrow_q);
    sum_lo_d  = sum_lo_q;
    sum_msb_d = sum_msb_q;
    opa_d     = opa_q;
    work_d    = work_q;
    borrow_d  = borrow_q;
    step_d    = step_q;
    opb_d     = opb_q;
    err_d     = err_q;
    if (state_q == StIdle && in_valid) begin
      sum_lo_d  = in_sum[WIDTH-1:0];
      sum_msb_d = in_sum[WIDTH];
      opa_d     = in_opa;
      work_d    = '0;
      borrow_d  = 1'b0;
      step_d    = '0;
    end else if (state_q == StRun) begin
      sum_lo_d = sum_lo_q >> DIGIT;
      opa_d    = opa_q >> DIGIT;
      work_d   = (work_q >> DIGIT) | (WIDTH'(diff[DIGIT-1:0]) << (WIDTH - DIGIT));
      borrow_d = diff[DIGIT];
      step_d   = step_q + 1'b1;
      if (step_q == LastStep) begin
        opb_d = work_d;
        // S[WIDTH] - borrow is nonzero exactly when the two bits differ
        err_d = sum_msb_q ^ diff[DIGIT];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_lo_q  <= '0;
      sum_msb_q <= 1'b0;
      opa_q     <= '0;
      work_q    <= '0;
      borrow_q  <= 1'b0;
      step_q    <= '0;
      opb_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      sum_lo_q  <= sum_lo_d;
      sum_msb_q <= sum_msb_d;
      opa_q     <= opa_d;
      work_q    <= work_d;
      borrow_q  <= borrow_d;
      step_q    <= step_d;
      opb_q     <= opb_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_sum_operand_recover_seq.sv
// Directed and randomized bench for sum_operand_recover_seq against an
// arithmetic reference model of {err, (S - A) mod 2^12}.
module tb_sum_operand_recover_seq;
  localparam int W = 12;
  localparam int D = 2;
  localparam int N = W / D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W:0]   in_sum = '0;
  logic [W-1:0] in_opa = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_opb;
  logic         out_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sum_operand_recover_seq #(.WIDTH(W), .DIGIT(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_opa    (in_opa),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_opb   (out_opb),
    .out_err   (out_err)
  );

  // Returns {err, opb}
  function automatic logic [12:0] ref_model(int s, int a);
    int d;
    d = s - a;
    ref_model = {(d < 0 || d >= 4096), 12'(d & 32'hFFF)};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [12:0] s, input logic [11:0] a);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("issue_ready", 32'(in_ready), 1);
    in_sum   = s;
    in_opa   = a;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Called right after the accept edge; checks latency, value, hold and release.
  task automatic collect(string tag, int stall, logic [12:0] exp);
    int n = 0;
    logic [11:0] h_opb;
    logic h_err;
    out_ready = 1'b0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(N));
    check({tag, "_opb"}, 32'(out_opb), 32'(exp[11:0]));
    check({tag, "_err"}, 32'(out_err), 32'(exp[12]));
    h_opb = out_opb;
    h_err = out_err;
    for (int i = 0; i < stall; i++) begin
      check({tag, "_busy"}, 32'(in_ready), 0);
      tick();
      check({tag, "_hold_valid"}, 32'(out_valid), 1);
      check({tag, "_hold_opb"}, 32'(out_opb), 32'(h_opb));
      check({tag, "_hold_err"}, 32'(out_err), 32'(h_err));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drop"}, 32'(out_valid), 0);
    check({tag, "_idle"}, 32'(in_ready), 1);
  endtask

  task automatic stream(string tag, int npairs, bit rnd, bit in_range, bit chk_period);
    logic [12:0] q[$];
    logic [12:0] s;
    logic [11:0] a;
    logic [12:0] exp;
    logic [11:0] p_opb;
    logic p_err, acc, fire, hold;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int last = -1;
    a = 12'($urandom);
    s = in_range ? 13'(a) + 13'(12'($urandom)) : 13'($urandom);
    in_sum    = s;
    in_opa    = a;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (got < npairs && cyc < npairs * 40 + 100) begin
      acc   = in_valid && in_ready;
      fire  = out_valid && out_ready;
      hold  = out_valid && !out_ready;
      p_opb = out_opb;
      p_err = out_err;
      tick();
      cyc++;
      if (hold) begin
        check({tag, "_stall_valid"}, 32'(out_valid), 1);
        check({tag, "_stall_opb"}, 32'(out_opb), 32'(p_opb));
        check({tag, "_stall_err"}, 32'(out_err), 32'(p_err));
      end
      if (fire) begin
        if (q.size() == 0) begin
          check({tag, "_spurious"}, 1, 0);
        end else begin
          exp = q.pop_front();
          check({tag, "_opb"}, 32'(p_opb), 32'(exp[11:0]));
          check({tag, "_err"}, 32'(p_err), 32'(exp[12]));
        end
        if (chk_period && last >= 0) check({tag, "_period"}, 32'(cyc - last), 32'(N + 2));
        last = cyc;
        got++;
      end
      if (acc) begin
        q.push_back(ref_model(int'(s), int'(a)));
        sent++;
        a = 12'($urandom);
        s = in_range ? 13'(a) + 13'(12'($urandom)) : 13'($urandom);
        in_sum = s;
        in_opa = a;
      end
      if (sent >= npairs) in_valid = 1'b0;
      else in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({tag, "_count"}, 32'(got), 32'(npairs));
    tick();
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_opb", 32'(out_opb), 0);
    check("rst_err", 32'(out_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1. Maximal in-range case
    issue(13'h1FFE, 12'hFFF);
    collect("t1", 0, ref_model(32'h1FFE, 32'hFFF));
    check("t1_const", 32'(ref_model(32'h1FFE, 32'hFFF)), 32'h0FFF);

    // 2. Underflow and B overflow
    issue(13'h0005, 12'h007);
    collect("t2_under", 0, 13'h1FFE);
    issue(13'h1000, 12'h000);
    collect("t2_over", 0, 13'h1000);

    // 3. Backpressure with a second request held during RUN/DONE
    issue(13'h0800, 12'h123);
    in_sum   = 13'h0100;
    in_opa   = 12'h001;
    in_valid = 1'b1;
    collect("t3", 10, 13'h06DD);
    tick();
    in_valid = 1'b0;
    collect("t3_second", 0, 13'h00FF);

    // 4. Reset in the middle of RUN
    issue(13'h1234, 12'h0AB);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("t4_rst_valid", 32'(out_valid), 0);
    check("t4_rst_ready", 32'(in_ready), 1);
    check("t4_rst_opb", 32'(out_opb), 0);
    check("t4_rst_err", 32'(out_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t4_no_valid", 32'(out_valid), 0);
    issue(13'h0100, 12'h001);
    collect("t4_after", 0, 13'h00FF);

    // 5. Back-to-back in-range stream
    stream("t5", 20, 1'b0, 1'b1, 1'b1);

    // 6. Random sweep with stalls
    stream("t6", 3000, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
